// File: rtl/instr_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
//   Shared widths and types for the instruction fetch queue.
//   ADDR_W    : program-counter width (word addressed)
//   INSTR_W   : instruction width
//   NOP_INSTR : value driven on instr_out whenever nothing is valid
//   fetch_entry_t : one buffered fetch, {pc, instr}
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue_if
//   Groups the instruction-memory read bus and the decode handshake.
//   master : the fetch queue (drives imem_req/imem_addr and instr_*)
//   slave  : the environment (memory returns imem_rvalid/imem_rdata,
//            decode returns instr_ready)
//   Signals:
//     imem_req, imem_addr   : read strobe and word address
//     imem_rvalid, imem_rdata : in-order read response
//     instr_valid, instr_out, instr_pc : instruction presented to decode
//     instr_ready           : decode accepts this cycle
// -----------------------------------------------------------------------------
interface instr_fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int N  = ADDR_W,
    parameter int IW = INSTR_W
) ();

    logic          imem_req;
    logic [N-1:0]  imem_addr;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [IW-1:0] instr_out;
    logic [N-1:0]  instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        input  imem_rvalid, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc,
        output imem_rvalid, imem_rdata, instr_ready
    );

endinterface

// File: rtl/instr_fetch_queue_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//   Small synchronous FIFO, DEPTH entries (power of 2) of WIDTH bits.
//   Pointers wrap modulo DEPTH; push and pop may occur in the same cycle.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     flush_i    : empty the FIFO next cycle (wins over push/pop)
//     push_i, wdata_i : write one entry
//     pop_i      : drop the head entry (ignored when empty)
//     rdata_o    : head entry
//     count_o    : number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i & (count_q != '0);
    assign do_push = push_i & ~flush_i;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only read once count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//   Fetches the instruction stream addressed by the PC: issues word reads to
//   instruction memory, buffers {pc, instr} pairs and hands them to decode
//   with valid/ready. A redirect discards buffered and in-flight fetches.
//   Parameters: N (PC width, must equal fetch_pkg::ADDR_W), IW (instruction
//   width, must equal fetch_pkg::INSTR_W), DEPTH (power of 2, >= 2).
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     pc_in, pc_valid : address to fetch this cycle
//     pc_hold    : upstream PC must not advance (no credit left)
//     redirect   : jump/taken branch; flush everything fetched so far
//     bus        : imem read bus + decode handshake (master modport)
//   Optional feature macro FETCH_BYPASS_EN: a live response that finds the
//   buffer empty while decode is ready goes straight to instr_* in the rvalid
//   cycle instead of being buffered.
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int N     = ADDR_W,
    parameter int IW    = INSTR_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N-1:0]               pc_in,
    input  logic                       pc_valid,
    output logic                       pc_hold,
    input  logic                       redirect,
    instr_fetch_queue_if.master        bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] FULL_LVL = (CNT_W + 1)'(DEPTH);

    logic [CNT_W-1:0] buf_count, outstanding;
    logic [CNT_W-1:0] stale_q, stale_d;
    logic [CNT_W:0]   used;
    logic             issue, resp, resp_live, bypass;
    logic             buf_valid, buf_push, buf_pop;
    fetch_entry_t     buf_head, buf_wdata;
    logic [N-1:0]     pcq_head;

    // Credit: every buffer slot is reserved at issue time, so a response can never find the buffer full.
    assign used    = {1'b0, buf_count} + {1'b0, outstanding};
    assign pc_hold = (used >= FULL_LVL);

    assign issue         = pc_valid & ~pc_hold & ~redirect;
    assign bus.imem_req  = issue;
    assign bus.imem_addr = issue ? pc_in : '0;

    // Responses with nothing outstanding are leftovers from before a reset.
    assign resp      = bus.imem_rvalid & (outstanding != '0);
    assign resp_live = resp & (stale_q == '0) & ~redirect;

    assign buf_valid = (buf_count != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass = resp_live & ~buf_valid & bus.instr_ready;
`else
    assign bypass = 1'b0;
`endif

    assign buf_push        = resp_live & ~bypass;
    assign buf_pop         = buf_valid & bus.instr_ready;
    assign buf_wdata.pc    = pcq_head;
    assign buf_wdata.instr = bus.imem_rdata;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(N + IW)) u_instr_buf (
        .clk     (clk),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (buf_push),
        .pop_i   (buf_pop),
        .wdata_i (buf_wdata),
        .rdata_o (buf_head),
        .count_o (buf_count)
    );

    // PCs of issued requests; memory answers in order, so the head names the next response.
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(N)) u_pc_queue (
        .clk     (clk),
        .reset   (reset),
        .flush_i (1'b0),
        .push_i  (issue),
        .pop_i   (resp),
        .wdata_i (pc_in),
        .rdata_o (pcq_head),
        .count_o (outstanding)
    );

    // On redirect every request still in flight after this cycle is stale.
    always_comb begin
        stale_d = stale_q;
        if (redirect)
            stale_d = outstanding - CNT_W'(resp);
        else if (resp && (stale_q != '0))
            stale_d = stale_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) stale_q <= '0;
        else       stale_q <= stale_d;
    end

    always_comb begin
        bus.instr_valid = buf_valid;
        bus.instr_out   = buf_valid ? buf_head.instr : NOP_INSTR;
        bus.instr_pc    = buf_valid ? buf_head.pc : '0;
        if (bypass) begin
            bus.instr_valid = 1'b1;
            bus.instr_out   = bus.imem_rdata;
            bus.instr_pc    = pcq_head;
        end
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (reset) used <= FULL_LVL);
    a_stale_bound:  assert property (@(posedge clk) disable iff (reset) stale_q <= outstanding);

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
//   Drives instr_fetch_queue with directed scenarios followed by a randomized
//   stream, against a queue-based reference model: an in-order memory with
//   per-request latency, a list of buffered (pc, instr) pairs, and staleness
//   marked per in-flight request rather than counted.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_valid;
    logic              pc_hold;
    logic              redirect;

    instr_fetch_queue_if bus_if ();

    instr_fetch_queue #(.N(ADDR_W), .IW(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .pc_in    (pc_in),
        .pc_valid (pc_valid),
        .pc_hold  (pc_hold),
        .redirect (redirect),
        .bus      (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pc;
        int                due;
        bit                stale;
        bit                orphan;
    } mem_req_t;

    mem_req_t          mem_q[$];
    fetch_entry_t      buf_q[$];
    int                cyc, last_due, lat;
    logic [ADDR_W-1:0] pc_reg;
    int                tests_run, tests_failed;
    bit                after_reset;
    bit                watch_on, watch_hit;
    logic [ADDR_W-1:0] watch_pc;
    int                watch_cyc;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs after negedge, compare against the model, advance the model.
    task automatic cycle(input bit rst, input bit pv, input bit redir,
                         input logic [ADDR_W-1:0] target, input bit rdy);
        int           outstanding, due;
        bit           rv, hold, req, resp_live, byp, valid;
        fetch_entry_t head, e;
        mem_req_t     r;

        @(negedge clk);
        reset                = rst;
        pc_valid             = pv;
        pc_in                = pc_reg;
        redirect             = redir;
        bus_if.instr_ready   = rdy;
        rv                   = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus_if.imem_rvalid   = rv;
        bus_if.imem_rdata    = rv ? mem_word(mem_q[0].pc) : $urandom();
        #1;

        outstanding = 0;
        foreach (mem_q[i]) if (!mem_q[i].orphan) outstanding++;
        hold      = (buf_q.size() + outstanding) >= DEPTH;
        req       = pv && !hold && !redir && !rst;
        resp_live = rv && !mem_q[0].orphan && !mem_q[0].stale && !redir;
        byp       = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp       = resp_live && (buf_q.size() == 0) && rdy;
`endif
        valid     = (buf_q.size() != 0) || byp;
        head      = '0;
        if (byp) begin
            head.pc    = mem_q[0].pc;
            head.instr = mem_word(mem_q[0].pc);
        end else if (buf_q.size() != 0) begin
            head = buf_q[0];
        end

        if (!rst) begin
            check("pc_hold", pc_hold, hold);
            check("imem_req", bus_if.imem_req, req);
            if (req) check("imem_addr", bus_if.imem_addr, pc_reg);
            check("instr_valid", bus_if.instr_valid, valid);
            if (valid) begin
                check("instr_pc", bus_if.instr_pc, head.pc);
                check("instr_out", bus_if.instr_out, head.instr);
            end
            if (after_reset) begin
                check("rst_instr_out", bus_if.instr_out, 0);
                check("rst_instr_pc", bus_if.instr_pc, 0);
                check("rst_imem_addr", bus_if.imem_addr, 0);
                after_reset = 1'b0;
            end
            if (watch_on && !watch_hit && bus_if.instr_valid) begin
                watch_hit = 1'b1;
                watch_pc  = bus_if.instr_pc;
                watch_cyc = cyc;
            end
        end

        if (rst) begin
            if (rv) void'(mem_q.pop_front());
            foreach (mem_q[i]) mem_q[i].orphan = 1'b1;
            buf_q.delete();
            after_reset = 1'b1;
            pc_reg      = '0;
        end else begin
            if (valid && rdy && !byp) void'(buf_q.pop_front());
            if (rv) begin
                r = mem_q.pop_front();
                if (resp_live && !byp) begin
                    e.pc    = r.pc;
                    e.instr = mem_word(r.pc);
                    buf_q.push_back(e);
                end
            end
            if (redir) begin
                buf_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            end
            if (req) begin
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{pc: pc_reg, due: due, stale: 1'b0, orphan: 1'b0});
            end
            if (redir)    pc_reg = target;
            else if (req) pc_reg = pc_reg + 1;
        end
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (mem_q.size() != 0 || buf_q.size() != 0); k++)
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("drain_left", mem_q.size() + buf_q.size(), 0);
    endtask

    initial begin
        int issue_cyc, k;
        tests_run = 0; tests_failed = 0;
        cyc = 0; last_due = -1; lat = 1; pc_reg = '0;
        after_reset = 1'b0; watch_on = 1'b0; watch_hit = 1'b0;
        reset = 1'b1; pc_valid = 1'b0; pc_in = '0; redirect = 1'b0;
        bus_if.imem_rvalid = 1'b0; bus_if.imem_rdata = '0; bus_if.instr_ready = 1'b0;

        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);

        // 1: stream, L=1, decode always ready
        lat = 1;
        repeat (12) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        drain();

        // 2: backpressure, then release
        repeat (8)  cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
        check("bp_hold", pc_hold, 1'b1);
        check("bp_req", bus_if.imem_req, 1'b0);
        repeat (10) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        drain();

        // 3: two in flight (L=3), redirect at pc 5 to pc 40
        lat = 3; pc_reg = 3;
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 40, 1'b1);
        watch_on = 1'b1; watch_hit = 1'b0;
        repeat (10) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        check("redir_seen", watch_hit, 1'b1);
        check("redir_first_pc", watch_pc, 40);
        watch_on = 1'b0;
        drain();

        // 4: redirect together with a response and a pop
        lat = 2;
        k = 0;
        while (k < 20 && !(buf_q.size() != 0 && mem_q.size() != 0 && mem_q[0].due <= cyc)) begin
            cycle(1'b0, 1'b1, 1'b0, '0, 1'b0);
            k++;
        end
        check("simul_setup", k < 20, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 100, 1'b1);
        @(posedge clk); #1;
        check("simul_buf_empty", bus_if.instr_valid, 1'b0);
        repeat (6) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        drain();

        // 5: reset with three requests outstanding
        lat = 4; pc_reg = 20;
        repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        check("rst_setup", mem_q.size(), 3);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        for (int j = 0; j < 20 && mem_q.size() != 0; j++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("rst_orphans_left", mem_q.size(), 0);
        check("rst_no_valid", bus_if.instr_valid, 1'b0);
        lat = 1;
        watch_on = 1'b1; watch_hit = 1'b0;
        repeat (8) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        check("restart_seen", watch_hit, 1'b1);
        check("restart_pc", watch_pc, 0);
        watch_on = 1'b0;
        drain();

        // 6: single fetch of pc 8 into an empty buffer, L=1
        lat = 1; pc_reg = 8;
        watch_on = 1'b1; watch_hit = 1'b0;
        issue_cyc = cyc;
        cycle(1'b0, 1'b1, 1'b0, '0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("lat_seen", watch_hit, 1'b1);
        check("lat_pc", watch_pc, 8);
`ifdef FETCH_BYPASS_EN
        check("lat_cycles", watch_cyc - issue_cyc, 1);
`else
        check("lat_cycles", watch_cyc - issue_cyc, 2);
`endif
        watch_on = 1'b0;
        drain();

        // Randomized traffic: latency, valid, ready and redirects all vary.
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) lat = $urandom_range(1, 4);
            cycle(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                  $urandom(), $urandom_range(0, 3) != 0);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
